exp_align_ctrl: RTL and testbench

Sequencer for the exponent path of the IEEE754 adder. It drives the shared 8-bit exponent add/sub ALU through compare, subtract and pass phases, and pulses the mantissa alignment shifter once per bit of exponent difference. When alignment is finished it returns the larger exponent to the normalize stage.

---
 rtl/fp_add_pkg.sv | 8 +
 rtl/align_counter.sv | 28 ++
 rtl/exp_align_ctrl.sv | 78 +++++++
 tb/tb_exp_align_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared FSM states, exponent ALU selects and the default alignment ceiling.
package fp_add_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMP, S_ALIGN, S_EXP, S_DONE} state_t;
  localparam logic [1:0] ALU_B_MINUS_A = 2'b00;
  localparam logic [1:0] ALU_A_MINUS_B = 2'b01;
  localparam logic [1:0] ALU_PASS_A    = 2'b10;
  localparam int MAX_SHIFT_DEF = 24;
endpackage

// File: rtl/align_counter.sv
// align_counter: 8-bit loadable down-counter for alignment shifts; ALIGN_SAT_EN clamps the load to MAX_SHIFT.
module align_counter
  import fp_add_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [7:0] d_i,
  output logic       last_o,
  output logic       zero_o
);
  localparam logic [7:0] SAT = 8'(MAX_SHIFT);
`ifdef ALIGN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? ((SAT_EN && d_i > SAT) ? SAT : d_i) : dec_i ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last_o = cnt_q == 8'd1;
  assign zero_o = cnt_q == 8'd0;
endmodule

// File: rtl/exp_align_ctrl.sv
// exp_align_ctrl: exponent-path sequencer of the FP adder (compare, align shifts, larger exponent out).
// Optional ALIGN_SAT_EN caps the shift count at MAX_SHIFT.
module exp_align_ctrl
  import fp_add_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_a,
  input  logic [7:0] exp_b,
  input  logic [7:0] alu_res,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_sel,
  output logic       shift_en,
  output logic       shift_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] exp_out
);
  state_t state_q, state_d;
  logic [7:0] ea_q, eb_q, exp_out_q;
  logic shift_b_q, last, zero, ge;
  assign ge = ea_q >= eb_q;
  align_counter #(.MAX_SHIFT(MAX_SHIFT)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load_i(state_q == S_CMP), .dec_i(state_q == S_ALIGN),
    .d_i(alu_res), .last_o(last), .zero_o(zero)
  );
  always_comb begin
    state_d = state_q;
    alu_a = '0;
    alu_b = '0;
    alu_sel = ALU_PASS_A;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_CMP : S_IDLE;
      S_CMP: begin
        alu_a = ea_q;
        alu_b = eb_q;
        alu_sel = ge ? ALU_A_MINUS_B : ALU_B_MINUS_A;
        state_d = alu_res != 8'd0 ? S_ALIGN : S_EXP;
      end
      S_ALIGN: begin
        shift_en = 1'b1;
        state_d = (last || zero) ? S_EXP : S_ALIGN;
      end
      S_EXP: begin
        alu_a = shift_b_q ? ea_q : eb_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ea_q <= '0;
      eb_q <= '0;
      shift_b_q <= 1'b0;
      exp_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        ea_q <= exp_a;
        eb_q <= exp_b;
      end
      if (state_q == S_CMP) shift_b_q <= ge;
      if (state_q == S_EXP) exp_out_q <= alu_res;
    end
  end
  // shift_b must already be valid in CMP, before the compare result is registered
  assign shift_b = state_q == S_CMP ? ge : shift_b_q;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign exp_out = exp_out_q;
endmodule

// File: tb/tb_exp_align_ctrl.sv
// tb_exp_align_ctrl: scoreboard bench for exp_align_ctrl with a behavioural exponent ALU.
module tb_exp_align_ctrl;
  logic clk, rst_n, start, shift_en, shift_b, busy, done;
  logic [7:0] exp_a, exp_b, alu_res, alu_a, alu_b, exp_out;
  logic [1:0] alu_sel;
`ifdef ALIGN_SAT_EN
  localparam int NFE = 24;
  localparam int NMAX = 24;
`else
  localparam int NFE = 253;
  localparam int NMAX = 255;
`endif
  typedef struct {
    logic [7:0] e;
    int n;
    logic [1:0] sel;
    logic sb;
    int c0;
  } txn_t;
  txn_t q[$];
  int tests = 0, fails = 0, dones = 0, cyc = 0;
  exp_align_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_a(exp_a), .exp_b(exp_b),
    .alu_res(alu_res), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .shift_en(shift_en), .shift_b(shift_b), .busy(busy), .done(done), .exp_out(exp_out)
  );
  always_comb alu_res = alu_sel == 2'b00 ? alu_b - alu_a : alu_sel == 2'b01 ? alu_a - alu_b : alu_a;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  logic busy_p = 0;
  int shn = 0;
  logic [1:0] sel_c = 2'b11;
  always @(negedge clk) begin
    txn_t t;
    if (busy && !busy_p) begin
      sel_c = alu_sel;
      shn = 0;
    end
    if (shift_en) shn++;
    if (done) begin
      dones++;
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        t = q.pop_front();
        chk("exp_out", int'(exp_out), int'(t.e));
        chk("shift_count", shn, t.n);
        chk("cmp_alu_sel", int'(sel_c), int'(t.sel));
        chk("shift_b", int'(shift_b), int'(t.sb));
        chk("done_latency", cyc - t.c0, t.n + 3);
      end
    end
    busy_p = busy;
  end
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e,
                     input int n, input logic [1:0] sel, input logic sb);
    int d0, w;
    d0 = dones;
    w = 0;
    @(negedge clk);
    exp_a = a;
    exp_b = b;
    start = 1;
    q.push_back('{e, n, sel, sb, cyc});
    @(negedge clk);
    start = 0;
    while (dones == d0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", dones - d0, 1);
  endtask
  initial begin
    int c, d0;
    rst_n = 0;
    start = 0;
    exp_a = 0;
    exp_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_shift_b", int'(shift_b), 0);
    chk("rst_exp_out", int'(exp_out), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_sel", int'(alu_sel), 2);
    rst_n = 1;
    run(8'h85, 8'h80, 8'h85, 5, 2'b01, 1'b1);
    run(8'h10, 8'h12, 8'h12, 2, 2'b00, 1'b0);
    run(8'h7F, 8'h7F, 8'h7F, 0, 2'b01, 1'b1);
    run(8'h01, 8'h00, 8'h01, 1, 2'b01, 1'b1);
    run(8'hFE, 8'h01, 8'hFE, NFE, 2'b01, 1'b1);
    run(8'h00, 8'hFF, 8'hFF, NMAX, 2'b00, 1'b0);
    // reset in the third ALIGN cycle abandons the operation
    @(negedge clk);
    exp_a = 8'h85;
    exp_b = 8'h80;
    start = 1;
    c = cyc;
    @(negedge clk);
    start = 0;
    while (cyc < c + 4) @(negedge clk);
    chk("pre_rst_shift_en", int'(shift_en), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_shift_en", int'(shift_en), 0);
    chk("midrst_alu_sel", int'(alu_sel), 2);
    chk("midrst_exp_out", int'(exp_out), 0);
    chk("midrst_done", int'(done), 0);
    run(8'h20, 8'h23, 8'h23, 3, 2'b00, 1'b0);
    // start re-pulsed during ALIGN and during DONE must be ignored
    d0 = dones;
    @(negedge clk);
    exp_a = 8'h85;
    exp_b = 8'h80;
    start = 1;
    c = cyc;
    q.push_back('{8'h85, 5, 2'b01, 1'b1, c});
    @(negedge clk);
    start = 0;
    while (cyc < c + 3) @(negedge clk);
    exp_a = 8'h00;
    exp_b = 8'h40;
    start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < c + 8) @(negedge clk);
    chk("done_at_8", int'(done), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    chk("ignored_busy", int'(busy), 0);
    chk("ignored_dones", dones - d0, 1);
    chk("ignored_exp_out", int'(exp_out), 8'h85);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
